// File: rtl/tx_frame_gen.sv
// MAC-client frame generator: START/ACK handshake, incrementing payload, programmable
// gap, optional underrun injection, ACK timeout and pause-frame requests.
module tx_frame_gen #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned LEN_W       = 14,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned GAP_W       = 8,
  parameter int unsigned MIN_BYTES   = 16,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic                  TX_CLK,
  input  logic                  RESET,
  input  logic                  cfg_go,
  input  logic                  cfg_stop,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic [CNT_W-1:0]      cfg_num_frames,
  input  logic [GAP_W-1:0]      cfg_gap,
  input  logic [DATA_W-1:0]     cfg_seed,
  input  logic                  cfg_urun_en,
  input  logic [LEN_W-1:0]      cfg_urun_word,
  input  logic                  pause_req,
  input  logic [15:0]           pause_quanta,
  input  logic                  TX_ACK,
  output logic                  TX_START,
  output logic [DATA_W-1:0]     TX_DATA,
  output logic [DATA_W/8-1:0]   TX_DATA_VALID,
  output logic                  TX_UNDERRUN,
  output logic [15:0]           FC_TRANS_PAUSEDATA,
  output logic                  FC_TRANS_PAUSEVAL,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      frames_sent,
  output logic                  ack_timeout_err
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned BIDX_W = $clog2(BYTES);
  localparam int unsigned TMO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned LENX_W = LEN_W + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              start_q, start_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [BYTES-1:0]  valid_q, valid_d;
  logic              urun_q, urun_d;
  logic              urun0_q, urun0_d;
  logic [LEN_W-1:0]  widx_q, widx_d;
  logic [LEN_W-1:0]  words_q, words_d;
  logic [BIDX_W-1:0] rem_q, rem_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0]  gap_len_q, gap_len_d;
  logic              urun_en_q, urun_en_d;
  logic [LEN_W-1:0]  urun_word_q, urun_word_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  run_q, run_d;
  logic [CNT_W-1:0]  frames_q, frames_d;
  logic              stop_q, stop_d;
  logic              pend_q, pend_d;
  logic [15:0]       quanta_q, quanta_d;
  logic              pval_q, pval_d;
  logic [15:0]       pdata_q, pdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              start_frame, end_frame, next_word;
  logic [LEN_W-1:0]  nidx, eff_len, words_calc;
  logic [LENX_W-1:0] len_round;
  logic [BYTES-1:0]  last_mask;

  // Byte-valid mask for the final word of a frame.
  always_comb begin
    last_mask = '0;
    for (int i = 0; i < BYTES; i++) begin
      last_mask[i] = (rem_q == '0) || (BIDX_W'(i) < rem_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    data_d      = data_q;
    valid_d     = valid_q;
    urun_d      = 1'b0;
    urun0_d     = urun0_q;
    widx_d      = widx_q;
    words_d     = words_q;
    rem_d       = rem_q;
    tmo_d       = tmo_q;
    gap_cnt_d   = gap_cnt_q;
    gap_len_d   = gap_len_q;
    urun_en_d   = urun_en_q;
    urun_word_d = urun_word_q;
    num_d       = num_q;
    run_d       = run_q;
    frames_d    = frames_q;
    stop_d      = stop_q;
    pend_d      = pend_q;
    quanta_d    = quanta_q;
    pval_d      = 1'b0;
    pdata_d     = 16'd0;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    next_word   = 1'b0;
    nidx        = widx_q + LEN_W'(1);
    eff_len     = (cfg_len < LEN_W'(MIN_BYTES)) ? LEN_W'(MIN_BYTES) : cfg_len;
    len_round   = LENX_W'(eff_len) + LENX_W'(BYTES - 1);
    words_calc  = LEN_W'(len_round >> BIDX_W);

    if (cfg_stop && (state_q == S_REQ || state_q == S_DATA || state_q == S_GAP)) begin
      stop_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (cfg_go) begin
          start_frame = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          err_d       = 1'b0;
          run_d       = '0;
          num_d       = cfg_num_frames;
          stop_d      = 1'b0;
        end
      end
      S_REQ: begin
        // An ACK on the last allowed cycle still wins over the timeout.
        if (TX_ACK) begin
          if (urun0_q) end_frame = 1'b1;
          else         next_word = 1'b1;
        end else if (tmo_q == TMO_W'(ACK_TIMEOUT)) begin
          err_d     = 1'b1;
          end_frame = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DATA: begin
        if (urun_q || widx_q == words_q - LEN_W'(1)) end_frame = 1'b1;
        else                                         next_word = 1'b1;
      end
      S_GAP: begin
        if (gap_cnt_q == gap_len_q) begin
          if (stop_q || (num_q != '0 && run_q == num_q)) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            stop_d  = 1'b0;
          end else begin
            start_frame = 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (next_word) begin
      state_d = S_DATA;
      widx_d  = nidx;
      data_d  = data_q + DATA_W'(1);
      valid_d = (nidx == words_q - LEN_W'(1)) ? last_mask : '1;
      urun_d  = urun_en_q && (urun_word_q == nidx);
      urun0_d = 1'b0;
    end

    if (end_frame) begin
      state_d   = S_GAP;
      valid_d   = '0;
      urun0_d   = 1'b0;
      gap_cnt_d = GAP_W'(1);
      frames_d  = frames_q + CNT_W'(1);
      run_d     = run_q + CNT_W'(1);
    end

    // Frame configuration is captured at every frame start.
    if (start_frame) begin
      state_d     = S_REQ;
      start_d     = 1'b1;
      data_d      = cfg_seed;
      valid_d     = '1;
      widx_d      = '0;
      tmo_d       = TMO_W'(1);
      words_d     = words_calc;
      rem_d       = eff_len[BIDX_W-1:0];
      urun_en_d   = cfg_urun_en;
      urun_word_d = cfg_urun_word;
      urun0_d     = cfg_urun_en && (cfg_urun_word == '0);
      gap_len_d   = (cfg_gap == '0) ? GAP_W'(1) : cfg_gap;
    end

    // Pause pulses only land outside REQ/DATA; a new request re-arms after the pulse.
    if (pend_q && (state_d == S_IDLE || state_d == S_GAP || state_d == S_DONE)) begin
      pval_d  = 1'b1;
      pdata_d = quanta_q;
      pend_d  = 1'b0;
    end
    if (pause_req) begin
      pend_d   = 1'b1;
      quanta_d = pause_quanta;
    end
  end

  always_ff @(posedge TX_CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      data_q      <= '0;
      valid_q     <= '0;
      urun_q      <= 1'b0;
      urun0_q     <= 1'b0;
      widx_q      <= '0;
      words_q     <= '0;
      rem_q       <= '0;
      tmo_q       <= '0;
      gap_cnt_q   <= '0;
      gap_len_q   <= '0;
      urun_en_q   <= 1'b0;
      urun_word_q <= '0;
      num_q       <= '0;
      run_q       <= '0;
      frames_q    <= '0;
      stop_q      <= 1'b0;
      pend_q      <= 1'b0;
      quanta_q    <= '0;
      pval_q      <= 1'b0;
      pdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      urun_q      <= urun_d;
      urun0_q     <= urun0_d;
      widx_q      <= widx_d;
      words_q     <= words_d;
      rem_q       <= rem_d;
      tmo_q       <= tmo_d;
      gap_cnt_q   <= gap_cnt_d;
      gap_len_q   <= gap_len_d;
      urun_en_q   <= urun_en_d;
      urun_word_q <= urun_word_d;
      num_q       <= num_d;
      run_q       <= run_d;
      frames_q    <= frames_d;
      stop_q      <= stop_d;
      pend_q      <= pend_d;
      quanta_q    <= quanta_d;
      pval_q      <= pval_d;
      pdata_q     <= pdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // A word-0 underrun can only be qualified by the ACK itself.
  assign TX_UNDERRUN        = urun_q | (urun0_q & TX_ACK & (state_q == S_REQ));
  assign TX_START           = start_q;
  assign TX_DATA            = data_q;
  assign TX_DATA_VALID      = valid_q;
  assign FC_TRANS_PAUSEVAL  = pval_q;
  assign FC_TRANS_PAUSEDATA = pdata_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign frames_sent        = frames_q;
  assign ack_timeout_err    = err_q;

endmodule

// File: tb/tb_tx_frame_gen.sv
// Bench for tx_frame_gen: per-run expected traces built from frame-level rules,
// compared cycle by cycle against the DUT outputs.
module tb_tx_frame_gen;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned LEN_W  = 14;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned GAP_W  = 8;
  localparam int unsigned BYTES  = 8;
  localparam int MIN_LEN = 16;
  localparam int ACK_TO  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              cfg_go, cfg_stop, cfg_urun_en, pause_req, tx_ack;
  logic [LEN_W-1:0]  cfg_len, cfg_urun_word;
  logic [CNT_W-1:0]  cfg_num_frames;
  logic [GAP_W-1:0]  cfg_gap;
  logic [DATA_W-1:0] cfg_seed;
  logic [15:0]       pause_quanta;
  logic              tx_start, tx_underrun, pval, busy, done, ack_err;
  logic [DATA_W-1:0] tx_data;
  logic [BYTES-1:0]  tx_valid;
  logic [15:0]       pdata;
  logic [CNT_W-1:0]  frames_sent;

  tx_frame_gen dut (
    .TX_CLK(clk), .RESET(rst), .cfg_go(cfg_go), .cfg_stop(cfg_stop), .cfg_len(cfg_len),
    .cfg_num_frames(cfg_num_frames), .cfg_gap(cfg_gap), .cfg_seed(cfg_seed),
    .cfg_urun_en(cfg_urun_en), .cfg_urun_word(cfg_urun_word), .pause_req(pause_req),
    .pause_quanta(pause_quanta), .TX_ACK(tx_ack), .TX_START(tx_start), .TX_DATA(tx_data),
    .TX_DATA_VALID(tx_valid), .TX_UNDERRUN(tx_underrun), .FC_TRANS_PAUSEDATA(pdata),
    .FC_TRANS_PAUSEVAL(pval), .busy(busy), .done(done), .frames_sent(frames_sent),
    .ack_timeout_err(ack_err)
  );

  typedef struct packed {
    logic        ack;
    logic        go;
    logic        stop;
    logic        preq;
    logic [15:0] pq;
  } drv_t;
  typedef logic [109:0] obs_t;

  drv_t        drv_q[$];
  obs_t        exp_q[$];
  logic [15:0] fs_model;
  int          checks = 0;
  int          errors = 0;

  // {start, underrun, pauseval, busy, done, err, valid, pausedata, frames_sent, data-if-valid}
  function automatic obs_t pk(logic st, logic ur, logic pv, logic bz, logic dn, logic er,
                              logic [7:0] vl, logic [15:0] pd, logic [15:0] fs, logic [63:0] d);
    return {st, ur, pv, bz, dn, er, vl, pd, fs, (vl != 8'h00) ? d : 64'h0};
  endfunction

  function automatic obs_t observe();
    return pk(tx_start, tx_underrun, pval, busy, done, ack_err, tx_valid, pdata, frames_sent, tx_data);
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic apply(input drv_t d);
    cfg_go       = d.go;
    cfg_stop     = d.stop;
    tx_ack       = d.ack;
    pause_req    = d.preq;
    pause_quanta = d.pq;
  endtask

  // Build the expected per-cycle trace of one run from frame-level rules.
  task automatic plan(input int num, input int len, input logic [63:0] seed, input int gap,
                      input bit uen, input int uw, input int stop_frame, input bit pause_en,
                      input int lat_mode, input bit go_mid);
    int L, W, r, nfr, lat, nreq, last, fl, base, g;
    logic [7:0]  lastv, v;
    logic [15:0] q;
    logic        err_cur, pulse, to;
    drv_t        d, z;
    z = '0;
    drv_q.delete();
    exp_q.delete();
    L     = (len < MIN_LEN) ? MIN_LEN : len;
    W     = (L + BYTES - 1) / BYTES;
    r     = L % BYTES;
    lastv = (r != 0) ? 8'((1 << r) - 1) : 8'hFF;
    nfr   = (num != 0) ? num : stop_frame + 1;
    err_cur = 1'b0;
    for (int f = 0; f < nfr; f++) begin
      if (lat_mode >= 0) lat = lat_mode;
      else lat = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 5));
      to   = (lat >= ACK_TO);
      nreq = to ? ACK_TO : lat + 1;
      base = exp_q.size();
      for (int j = 0; j < nreq; j++) begin
        d = z;
        d.ack = !to && (j == nreq - 1);
        drv_q.push_back(d);
        exp_q.push_back(pk(j == 0, uen && uw == 0 && d.ack, 1'b0, 1'b1, 1'b0, err_cur,
                           8'hFF, 16'h0, fs_model, seed));
      end
      if (!to && !(uen && uw == 0)) begin
        last = (uen && uw < W) ? uw : W - 1;
        for (int k = 1; k <= last; k++) begin
          v = (k == W - 1) ? lastv : 8'hFF;
          drv_q.push_back(z);
          exp_q.push_back(pk(1'b0, uen && k == uw, 1'b0, 1'b1, 1'b0, err_cur, v, 16'h0,
                             fs_model, seed + 64'(k)));
        end
      end
      fl    = exp_q.size() - base;
      pulse = 1'b0;
      q     = 16'h0;
      if (pause_en && fl >= 2) begin
        int pc;
        pc = base + int'($urandom_range(0, fl - 2));
        q  = 16'($urandom);
        d = drv_q[pc]; d.preq = 1'b1; d.pq = q; drv_q[pc] = d;
        pulse = 1'b1;
      end
      if (f == stop_frame) begin
        int sc;
        sc = base + int'($urandom_range(0, fl - 1));
        d = drv_q[sc]; d.stop = 1'b1; drv_q[sc] = d;
      end
      if (go_mid && f == 0) begin
        d = drv_q[base + fl / 2]; d.go = 1'b1; drv_q[base + fl / 2] = d;
      end
      fs_model = fs_model + 16'd1;
      if (to) err_cur = 1'b1;
      g = (gap == 0) ? 1 : gap;
      for (int j = 0; j < g; j++) begin
        drv_q.push_back(z);
        exp_q.push_back(pk(1'b0, 1'b0, pulse && j == 0, 1'b1, 1'b0, err_cur, 8'h00,
                           (pulse && j == 0) ? q : 16'h0, fs_model, 64'h0));
      end
    end
    drv_q.push_back(z);
    exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, err_cur, 8'h00, 16'h0, fs_model, 64'h0));
  endtask

  task automatic run(input string name, input int num, input int len, input logic [63:0] seed,
                     input int gap, input bit uen, input int uw, input int stop_frame,
                     input bit pause_en, input int lat_mode, input bit go_mid);
    plan(num, len, seed, gap, uen, uw, stop_frame, pause_en, lat_mode, go_mid);
    @(posedge clk); #1;
    cfg_len        = LEN_W'(len);
    cfg_num_frames = CNT_W'(num);
    cfg_gap        = GAP_W'(gap);
    cfg_seed       = seed;
    cfg_urun_en    = uen;
    cfg_urun_word  = LEN_W'(uw);
    cfg_go         = 1'b1;
    for (int t = 0; t < exp_q.size(); t++) begin
      @(posedge clk); #1;
      apply(drv_q[t]);
      @(negedge clk);
      check($sformatf("%s_c%0d", name, t), observe(), exp_q[t]);
    end
    @(posedge clk); #1;
    apply('0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    apply('0);
    cfg_len = '0; cfg_num_frames = '0; cfg_gap = '0; cfg_seed = '0;
    cfg_urun_en = 1'b0; cfg_urun_word = '0;
    fs_model = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", observe(), '0);
    check("reset_data", 110'(tx_data), '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Pause from IDLE, then a request landing on the pulse cycle.
    pause_req = 1'b1; pause_quanta = 16'h1111;
    @(posedge clk); #1;
    pause_quanta = 16'h2222;
    @(negedge clk);
    check("pause_idle_lat", observe(), '0);
    @(posedge clk); #1;
    pause_req = 1'b0;
    @(negedge clk);
    check("pause_idle_old", observe(), pk(0, 0, 1, 0, 0, 0, 8'h0, 16'h1111, 16'h0, 64'h0));
    @(posedge clk); #1;
    @(negedge clk);
    check("pause_idle_new", observe(), pk(0, 0, 1, 0, 0, 0, 8'h0, 16'h2222, 16'h0, 64'h0));
    @(posedge clk); #1;
    @(negedge clk);
    check("pause_idle_end", observe(), '0);

    run("len67", 2, 67, 64'd1, 3, 0, 0, -1, 0, 3, 1);
    run("len64", 1, 64, 64'h10, 2, 0, 0, -1, 0, 0, 0);
    run("len5", 1, 5, 64'h20, 1, 0, 0, -1, 0, 1, 0);
    run("len16", 1, 16, 64'h30, 0, 0, 0, -1, 0, 2, 0);
    run("len17", 1, 17, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, -1, 0, 0, 0);
    run("timeout", 1, 40, 64'h40, 2, 0, 0, -1, 0, 99, 0);
    run("ack_late", 1, 24, 64'h48, 1, 0, 0, -1, 0, ACK_TO - 1, 0);
    run("urun4", 1, 67, 64'd100, 2, 1, 4, -1, 0, 1, 0);
    run("urun0", 1, 67, 64'd200, 1, 1, 0, -1, 0, 2, 0);
    run("urun_off", 1, 67, 64'd300, 1, 1, 9, -1, 0, 0, 0);
    run("pause", 1, 67, 64'd400, 2, 0, 0, -1, 1, 2, 0);
    run("stop", 0, 30, 64'd500, 2, 0, 0, 1, 0, 1, 0);

    for (int i = 0; i < 25; i++) begin
      int num;
      num = int'($urandom_range(0, 3));
      run($sformatf("rnd%0d", i), num, int'($urandom_range(0, 120)), {$urandom, $urandom},
          int'($urandom_range(0, 4)), $urandom_range(0, 3) == 0, int'($urandom_range(0, 17)),
          (num == 0) ? int'($urandom_range(0, 2)) : -1, 1'($urandom_range(0, 1)), -1,
          1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a frame, with a pause pending.
    @(posedge clk); #1;
    cfg_len = LEN_W'(100); cfg_num_frames = CNT_W'(1); cfg_urun_en = 1'b0; cfg_go = 1'b1;
    @(posedge clk); #1;
    cfg_go = 1'b0; tx_ack = 1'b1;
    @(posedge clk); #1;
    tx_ack = 1'b0; pause_req = 1'b1; pause_quanta = 16'h0BAD;
    @(negedge clk);
    check("mid_busy", 110'(busy && tx_valid == 8'hFF), 110'(1));
    @(posedge clk); #1;
    pause_req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_outs", observe(), '0);
    check("rst_mid_data", 110'(tx_data), '0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_nopause", observe(), '0);
    fs_model = 16'h0;
    run("after_rst", 1, 20, 64'h77, 1, 0, 0, -1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
